gf180mcu_fd_sc_mcu9t5v0__setn_gen: RTL and testbench



---
 rtl/gf180mcu_fd_sc_mcu9t5v0__setn_gen_if.sv | 27 ++
 rtl/gf180mcu_fd_sc_mcu9t5v0__setn_gen.sv | 123 ++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__setn_gen.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__setn_gen_if.sv
// SETN generator request/status bundle.
// master: drives SET_REQ, MIN_W; slave: drives SETN, BUSY, DONE.
interface gf180mcu_fd_sc_mcu9t5v0__setn_gen_if #(
    parameter int CNT_W = 4
);
    logic             SET_REQ;
    logic [CNT_W-1:0] MIN_W;
    logic             SETN;
    logic             BUSY;
    logic             DONE;

    modport master (
        output SET_REQ,
        output MIN_W,
        input  SETN,
        input  BUSY,
        input  DONE
    );

    modport slave (
        input  SET_REQ,
        input  MIN_W,
        output SETN,
        output BUSY,
        output DONE
    );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__setn_gen.sv
// Width-guaranteed, recovery-safe SETN source for dffnsnq banks.
// Ports: CLK, RST (async high), bus.slave (SET_REQ/MIN_W in, SETN/BUSY/DONE out).
module gf180mcu_fd_sc_mcu9t5v0__setn_gen #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4,
    parameter int RECOV       = 2
) (
    input  logic CLK,
    input  logic RST,
    gf180mcu_fd_sc_mcu9t5v0__setn_gen_if.slave bus
);

    typedef enum logic [1:0] {
        ST_POR,
        ST_IDLE,
        ST_ASSERT,
        ST_RECOVER
    } state_t;

    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] REC_M1 = CNT_W'(RECOV - 1);

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic                   por_ld;
    logic                   setn_q;
    logic                   busy_q;
    logic                   done_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic [CNT_W-1:0]       min_w;
    logic [CNT_W-1:0]       mw_m1;
    logic [CNT_W-1:0]       por_cnt;

    assign min_w = bus.MIN_W;
    assign req_s = sync_q[SYNC_STAGES-1];

    // max(MIN_W,1)-1
    assign mw_m1 = (min_w == '0) ? '0 : min_w - ONE;

    // The POR count is taken from MIN_W on the first edge after
    // reset release rather than loaded asynchronously inside reset.
    assign por_cnt = por_ld ? mw_m1 : cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.SET_REQ};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= ST_POR;
            cnt    <= '0;
            por_ld <= 1'b1;
            setn_q <= 1'b0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_POR: begin
                    por_ld <= 1'b0;
                    setn_q <= 1'b0;
                    busy_q <= 1'b1;
                    if (por_cnt == '0) begin
                        state  <= ST_RECOVER;
                        setn_q <= 1'b1;
                        cnt    <= REC_M1;
                    end else begin
                        cnt <= por_cnt - ONE;
                    end
                end
                ST_IDLE: begin
                    setn_q <= 1'b1;
                    busy_q <= 1'b0;
                    if (req_s) begin
                        state  <= ST_ASSERT;
                        setn_q <= 1'b0;
                        busy_q <= 1'b1;
                        cnt    <= mw_m1;
                    end
                end
                ST_ASSERT: begin
                    setn_q <= 1'b0;
                    busy_q <= 1'b1;
                    if (cnt != '0) begin
                        cnt <= cnt - ONE;
                    end else if (!req_s) begin
                        state  <= ST_RECOVER;
                        setn_q <= 1'b1;
                        cnt    <= REC_M1;
                    end
                end
                ST_RECOVER: begin
                    setn_q <= 1'b1;
                    busy_q <= 1'b1;
                    if (cnt == '0) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                default: begin
                    state  <= ST_POR;
                    cnt    <= '0;
                    por_ld <= 1'b1;
                    setn_q <= 1'b0;
                    busy_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.SETN = setn_q;
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__setn_gen.sv
// Scoreboard bench for the SETN generator.
// Stimulus pushes expected sequence records; a monitor pops on DONE.
module tb_gf180mcu_fd_sc_mcu9t5v0__setn_gen;

    localparam int SYNC  = 2;
    localparam int CW    = 4;
    localparam int RECOV = 2;

    typedef struct {
        int fall;
        int low;
        int rec;
    } exp_t;

    logic CLK;
    logic RST;

    gf180mcu_fd_sc_mcu9t5v0__setn_gen_if #(.CNT_W(CW)) bus ();

    gf180mcu_fd_sc_mcu9t5v0__setn_gen #(
        .SYNC_STAGES(SYNC),
        .CNT_W(CW),
        .RECOV(RECOV)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    time  t_pos  = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc++;
        t_pos = $time;
    end

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    task automatic chk(string nm, int act, int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d want %0d", nm, act, req);
    endtask

    // SETN may only move on a clock edge or while reset is high
    always @(bus.SETN) begin
        if ($time != 0)
            chk("setn_glitch", int'(($time == t_pos) || RST), 1);
    end

    // Monitor: measure low width, recovery width and fall cycle
    int low_n  = 0;
    int rec_n  = 0;
    int fall_c = -1;
    int bad    = 0;

    always @(negedge CLK) begin
        if (RST) begin
            low_n  = 0;
            rec_n  = 0;
            fall_c = -1;
            bad    = 0;
        end else if (!bus.SETN) begin
            if (low_n == 0) fall_c = cyc;
            low_n++;
            if (!bus.BUSY || bus.DONE) bad = 1;
        end else if (bus.BUSY) begin
            rec_n++;
            if (bus.DONE) bad = 1;
        end else if (bus.DONE) begin
            if (q.size() == 0) begin
                chk("done_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("low_width", low_n, e.low);
                chk("recov_width", rec_n, e.rec);
                if (e.fall >= 0) chk("fall_cycle", fall_c, e.fall);
                chk("busy_done_ok", bad, 0);
            end
            low_n  = 0;
            rec_n  = 0;
            fall_c = -1;
            bad    = 0;
        end
    end

    task automatic push(int fall, int low);
        exp_t e;
        e.fall = fall;
        e.low  = low;
        e.rec  = RECOV;
        q.push_back(e);
    endtask

    task automatic wait_idle(string nm);
        int k;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while ((bus.BUSY || q.size() != 0) && k < 300);
        if (k >= 300) chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic release_rst(int m);
        bus.MIN_W = CW'(m);
        @(posedge CLK);
        #2 RST = 1'b0;
        push(-1, imax(m, 1));
        @(posedge CLK);
        #1 bus.MIN_W = CW'($urandom_range(0, 15));
    endtask

    // Request held high for h sampling edges; optionally scramble MIN_W
    // once the request has been accepted.
    task automatic issue(int m, int h, bit chg, int chg_to);
        int c0;
        int n;
        @(negedge CLK);
        #1;
        bus.MIN_W   = CW'(m);
        bus.SET_REQ = 1'b1;
        c0 = cyc;
        push(c0 + 1 + SYNC, imax(imax(m, 1), h));
        n = imax(h, SYNC + 1);
        for (int k = 1; k <= n; k++) begin
            @(posedge CLK);
            #1;
            if (k == h) bus.SET_REQ = 1'b0;
            if (k == SYNC + 1 && chg) bus.MIN_W = CW'(chg_to);
        end
    endtask

    initial begin
        int k;
        RST         = 1'b1;
        bus.SET_REQ = 1'b0;
        bus.MIN_W   = CW'(3);
        #1;
        chk("rst_setn", int'(bus.SETN), 0);
        chk("rst_busy", int'(bus.BUSY), 1);
        chk("rst_done", int'(bus.DONE), 0);
        repeat (3) @(posedge CLK);

        // Reset release with MIN_W=3
        release_rst(3);
        wait_idle("por");
        chk("idle_busy", int'(bus.BUSY), 0);
        chk("idle_setn", int'(bus.SETN), 1);

        // Single-cycle pulse, MIN_W=4
        issue(4, 1, 1'b0, 0);
        wait_idle("pulse");

        // Held 10 cycles, MIN_W=2
        issue(2, 10, 1'b0, 0);
        wait_idle("hold");

        // MIN_W=0 behaves as 1
        issue(0, 1, 1'b0, 0);
        wait_idle("minw0");

        // MIN_W changed 5->1 after entry
        issue(5, 1, 1'b1, 1);
        wait_idle("minw_chg");

        // Re-request during recovery
        issue(2, 1, 1'b0, 0);
        k = 0;
        do begin
            @(posedge CLK);
            #1;
            k++;
        end while (!(bus.SETN && bus.BUSY) && k < 50);
        if (k >= 50) chk("recov_wait_timeout", 0, 1);
        issue(3, 6, 1'b0, 0);
        wait_idle("reassert");

        // Async reset mid-assert aborts the sequence
        issue(6, 1, 1'b0, 0);
        @(posedge CLK);
        #3 RST = 1'b1;
        #1;
        chk("abort_setn", int'(bus.SETN), 0);
        chk("abort_busy", int'(bus.BUSY), 1);
        chk("abort_done", int'(bus.DONE), 0);
        void'(q.pop_back());
        repeat (2) @(posedge CLK);
        release_rst(2);
        wait_idle("abort_por");

        // Random sequences
        for (int i = 0; i < 40; i++) begin
            int m;
            int h;
            m = $urandom_range(0, 7);
            h = $urandom_range(1, 12);
            issue(m, h, 1'($urandom_range(0, 1)), $urandom_range(0, 15));
            wait_idle("rand");
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end

        // Random-width POR
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        release_rst($urandom_range(0, 9));
        wait_idle("por_rand");

        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
